// File: rtl/countdown_timer_pkg.sv
// Shared types for the countdown timer: FSM states, speed codes, divisor lookup.
// Pure declarations; no logic, no latency.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [1:0] SPD_FAST = 2'd0;
    localparam logic [1:0] SPD_1X   = 2'd1;
    localparam logic [1:0] SPD_2X   = 2'd2;
    localparam logic [1:0] SPD_4X   = 2'd3;

    function automatic logic [31:0] divisor(input logic [1:0] speed, input int unsigned base);
        logic [31:0] d;
        case (speed)
            SPD_FAST: d = 32'd1;
            SPD_1X:   d = base;
            SPD_2X:   d = 2 * base;
            default:  d = 4 * base;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Run-control and count bus between a controller (master) and the timer (slave).
// Plain wires; no latency, no backpressure.
interface countdown_timer_if #(
    parameter int WIDTH = 8
);
    logic             Start;
    logic             Pause;
    logic [WIDTH-1:0] LoadValue;
    logic [1:0]       Speed;
    logic [WIDTH-1:0] CountValue;
    logic             Tick;
    logic             Running;
    logic             Done;

    modport master (
        output Start, Pause, LoadValue, Speed,
        input  CountValue, Tick, Running, Done
    );

    modport slave (
        input  Start, Pause, LoadValue, Speed,
        output CountValue, Tick, Running, Done
    );
endinterface

// File: rtl/countdown_timer_tick_gen.sv
// Prescaler: counts div_minus1 down to 0 and reloads; expire flags the zero cycle.
// load has priority, hold freezes the count; expire is combinational from the register.
module tick_gen #(
    parameter int DIV_WIDTH = 28
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 load,
    input  logic                 hold,
    input  logic [DIV_WIDTH-1:0] div_minus1,
    output logic                 expire
);
    logic [DIV_WIDTH-1:0] pre_q, pre_d;

    always_comb begin
        pre_d = pre_q;
        if (load) begin
            pre_d = div_minus1;
        end else if (!hold) begin
            if (pre_q == '0) begin
                pre_d = div_minus1;
            end else begin
                pre_d = pre_q - DIV_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

    assign expire = (pre_q == '0) && !hold;
endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter with rate divider and start/pause/restart/done FSM.
// Count, Tick and Done are registered; first Tick comes divisor cycles after Start.
module countdown_timer
    import timer_pkg::*;
#(
    parameter int          WIDTH     = 8,
    parameter int unsigned BASE_DIV  = 50_000_000,
    parameter int          DIV_WIDTH = 28
) (
    input  logic                Clock,
    input  logic                Reset,
    countdown_timer_if.slave    ctl
);
    state_t               state_q, state_d;
    logic [WIDTH-1:0]     count_q, count_d;
    logic                 tick_q, tick_d;
    logic                 done_q, done_d;
    logic [DIV_WIDTH-1:0] div_minus1;
    logic                 pre_hold;
    logic                 expire;
    logic                 active;
    logic                 last_dec;

    assign div_minus1 = DIV_WIDTH'(divisor(ctl.Speed, BASE_DIV) - 32'd1);

    // Releasing Pause in PAUSED counts on that same edge, so a pause of N cycles costs exactly N.
    assign active   = (state_q == RUN || state_q == PAUSED) && !ctl.Start && !ctl.Pause;
    assign pre_hold = !active;
    assign last_dec = active && expire && (count_q == WIDTH'(1));

    tick_gen #(.DIV_WIDTH(DIV_WIDTH)) u_tick (
        .Clock      (Clock),
        .Reset      (Reset),
        .load       (ctl.Start),
        .hold       (pre_hold),
        .div_minus1 (div_minus1),
        .expire     (expire)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (ctl.Start) begin
            state_d = (ctl.LoadValue == '0) ? DONE : RUN;
        end else begin
            case (state_q)
                RUN, PAUSED: begin
                    if (ctl.Pause)     state_d = PAUSED;
                    else if (last_dec) state_d = DONE;
                    else               state_d = RUN;
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        count_d = count_q;
        tick_d  = 1'b0;
        done_d  = 1'b0;
        if (ctl.Start) begin
            count_d = ctl.LoadValue;
            done_d  = (ctl.LoadValue == '0);
        end else if (active && expire && count_q != '0) begin
            count_d = count_q - WIDTH'(1);
            tick_d  = 1'b1;
            done_d  = last_dec;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            count_q <= '0;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            tick_q  <= tick_d;
            done_q  <= done_d;
        end
    end

    assign ctl.CountValue = count_q;
    assign ctl.Tick       = tick_q;
    assign ctl.Done       = done_q;
    assign ctl.Running    = (state_q == RUN);
endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with BASE_DIV=4; expectations are hand-computed per edge.
module tb_countdown_timer;
    import timer_pkg::*;

    localparam int WIDTH = 8;

    logic Clock;
    logic Reset;
    int   checks;
    int   failures;

    countdown_timer_if #(.WIDTH(WIDTH)) bus ();

    countdown_timer #(.WIDTH(WIDTH), .BASE_DIV(4), .DIV_WIDTH(5)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .ctl   (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Sample 1 time unit after the rising edge; inputs are also changed here.
    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    // Observed vector: {CountValue, Tick, Done, Running}
    function automatic logic [10:0] obs();
        return {bus.CountValue, bus.Tick, bus.Done, bus.Running};
    endfunction

    task automatic test_reset();
        Reset = 1'b1;
        step();
        step();
        checks++;
        if (obs() !== {8'd0, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_outputs: got %h want %h", obs(), {8'd0, 3'b000});
        end
        checks++;
        if (dut.state_q !== IDLE || dut.u_tick.pre_q !== 5'd0) begin
            failures++;
            $display("FAIL reset_state: state %0d pre %0d want 0 0", dut.state_q, dut.u_tick.pre_q);
        end
        Reset = 1'b0;
        step();
        checks++;
        if (obs() !== {8'd0, 3'b000}) begin
            failures++;
            $display("FAIL idle_hold: got %h want %h", obs(), {8'd0, 3'b000});
        end
    endtask

    task automatic test_fast();
        logic [10:0] exp;
        bus.Speed = SPD_FAST; bus.LoadValue = 8'd3; bus.Start = 1'b1;
        step();
        bus.Start = 1'b0;
        checks++;
        if (obs() !== {8'd3, 1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL fast_load: got %h want %h", obs(), {8'd3, 3'b001});
        end
        for (int i = 1; i <= 4; i++) begin
            step();
            exp = (i <= 3) ? {8'(3 - i), 1'b1, (i == 3), (i != 3)} : {8'd0, 3'b000};
            checks++;
            if (obs() !== exp) begin
                failures++;
                $display("FAIL fast_edge%0d: got %h want %h", i, obs(), exp);
            end
        end
    endtask

    task automatic test_slow();
        logic [10:0] exp;
        logic [7:0]  c;
        bus.Speed = SPD_1X; bus.LoadValue = 8'd2; bus.Start = 1'b1;
        step();
        bus.Start = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            step();
            c   = (i < 4) ? 8'd2 : (i < 8) ? 8'd1 : 8'd0;
            exp = {c, (i == 4 || i == 8), (i == 8), (i < 8)};
            checks++;
            if (obs() !== exp) begin
                failures++;
                $display("FAIL slow_edge%0d: got %h want %h", i, obs(), exp);
            end
        end
    endtask

    task automatic test_pause();
        bus.Speed = SPD_1X; bus.LoadValue = 8'd5; bus.Start = 1'b1;
        step();
        bus.Start = 1'b0;
        step();
        step();
        bus.Pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (obs() !== {8'd5, 3'b000} || dut.u_tick.pre_q !== 5'd1) begin
                failures++;
                $display("FAIL pause_hold%0d: got %h pre %0d want %h pre 1", i, obs(), dut.u_tick.pre_q, {8'd5, 3'b000});
            end
        end
        bus.Pause = 1'b0;
        step();
        checks++;
        if (obs() !== {8'd5, 3'b001}) begin
            failures++;
            $display("FAIL pause_resume1: got %h want %h", obs(), {8'd5, 3'b001});
        end
        step();
        checks++;
        if (obs() !== {8'd4, 3'b101}) begin
            failures++;
            $display("FAIL pause_tick: got %h want %h", obs(), {8'd4, 3'b101});
        end
        for (int i = 1; i <= 4; i++) begin
            step();
            checks++;
            if (obs() !== {((i == 4) ? 8'd3 : 8'd4), (i == 4), 2'b01}) begin
                failures++;
                $display("FAIL pause_after%0d: got %h", i, obs());
            end
        end
    endtask

    task automatic test_zero();
        bus.LoadValue = 8'd0; bus.Start = 1'b1;
        step();
        bus.Start = 1'b0;
        checks++;
        if (obs() !== {8'd0, 3'b010} || dut.state_q !== DONE) begin
            failures++;
            $display("FAIL zero_done: got %h state %0d want %h state 3", obs(), dut.state_q, {8'd0, 3'b010});
        end
        bus.Pause = 1'b1;
        step();
        bus.Pause = 1'b0;
        step();
        step();
        checks++;
        if (obs() !== {8'd0, 3'b000} || dut.state_q !== DONE) begin
            failures++;
            $display("FAIL zero_after: got %h state %0d want %h state 3", obs(), dut.state_q, {8'd0, 3'b000});
        end
    endtask

    task automatic test_restart();
        bus.Speed = SPD_1X; bus.LoadValue = 8'd5; bus.Start = 1'b1;
        step();
        bus.Start = 1'b0;
        step();
        step();
        bus.Start = 1'b1; bus.Pause = 1'b1; bus.LoadValue = 8'd7;
        step();
        bus.Start = 1'b0; bus.Pause = 1'b0;
        checks++;
        if (obs() !== {8'd7, 3'b001} || dut.state_q !== RUN || dut.u_tick.pre_q !== 5'd3) begin
            failures++;
            $display("FAIL restart: got %h state %0d pre %0d want %h state 1 pre 3", obs(), dut.state_q, dut.u_tick.pre_q, {8'd7, 3'b001});
        end
    endtask

    task automatic test_reset_midrun();
        bus.Speed = SPD_FAST; bus.LoadValue = 8'd4; bus.Start = 1'b1;
        step();
        bus.Start = 1'b0;
        step();
        step();
        checks++;
        if (obs() !== {8'd2, 3'b101}) begin
            failures++;
            $display("FAIL midrun_pre: got %h want %h", obs(), {8'd2, 3'b101});
        end
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        checks++;
        if (obs() !== {8'd0, 3'b000} || dut.state_q !== IDLE) begin
            failures++;
            $display("FAIL midrun_reset: got %h state %0d want 0 state 0", obs(), dut.state_q);
        end
        step();
        checks++;
        if (obs() !== {8'd0, 3'b000}) begin
            failures++;
            $display("FAIL midrun_nodone: got %h want 0", obs());
        end
    endtask

    task automatic test_speed_change();
        bus.Speed = SPD_1X; bus.LoadValue = 8'd3; bus.Start = 1'b1;
        step();
        bus.Start = 1'b0;
        step();
        step();
        bus.Speed = SPD_2X;
        for (int i = 3; i <= 12; i++) begin
            step();
            checks++;
            if (bus.Tick !== (i == 4 || i == 12) || bus.CountValue !== ((i < 4) ? 8'd3 : (i < 12) ? 8'd2 : 8'd1)) begin
                failures++;
                $display("FAIL speed_edge%0d: tick %0b count %0d", i, bus.Tick, bus.CountValue);
            end
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        Reset = 1'b1;
        bus.Start = 1'b0; bus.Pause = 1'b0; bus.LoadValue = '0; bus.Speed = SPD_FAST;
        test_reset();
        test_fast();
        test_slow();
        test_pause();
        test_zero();
        test_restart();
        test_reset_midrun();
        test_speed_change();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
Loadable down-counter with a built-in rate divider. It is the producer side of the count-enable interface used by our up-counters: it generates a one-cycle Tick at a selectable rate and counts a loaded value down to zero. A run-control FSM handles start, pause, restart and done, so the block can drive display digits or gate enables of downstream counters.

Parameters:
WIDTH, 8, width of LoadValue/CountValue.
BASE_DIV, 50_000_000, base divisor in Clock cycles (1 Hz at 50 MHz); must be >= 1.
DIV_WIDTH, 28, prescaler width; must hold 4*BASE_DIV-1.

Ports:
Clock  input  1  rising-edge clock.
Reset  input  1  synchronous, active-high reset.
Start  input  1  level-sampled; load LoadValue and run.
Pause  input  1  level; while 1 in RUN, hold count and prescaler.
LoadValue  input  WIDTH  start value, sampled when Start=1.
Speed  input  2  divisor select: 0 = 1, 1 = BASE_DIV, 2 = 2*BASE_DIV, 3 = 4*BASE_DIV.
CountValue  output  WIDTH  current count (registered).
Tick  output  1  one-cycle pulse on every decrement (registered).
Running  output  1  1 only in state RUN.
Done  output  1  one-cycle pulse when the count reaches 0 (registered).

Behaviour:
- Reset has priority over all inputs. After a reset edge: state IDLE, CountValue=0, prescaler=0, Tick=0, Done=0, Running=0. Reset mid-run aborts with no Done pulse.
- States are IDLE, RUN, PAUSED and DONE.
- Start has priority over Pause in every state.
- Start=1 at edge k, in any state:
  - CountValue<=LoadValue and prescaler<=divisor(Speed)-1.
  - Next state is RUN, or DONE if LoadValue=0. For LoadValue=0, Done=1 in the cycle after edge k.
  - A Start in RUN or PAUSED is a restart.
- RUN, with Start=0:
  - Pause=1: go to PAUSED; count and prescaler hold; Tick=0.
  - Otherwise, if prescaler!=0: prescaler decrements.
  - Otherwise (prescaler=0): prescaler reloads divisor(Speed)-1, CountValue decrements and Tick=1, all on the same edge.
  - If that decrement takes CountValue from 1 to 0: Done=1 on the same edge and next state is DONE.
- PAUSED: Pause=0 returns to RUN, resuming from the held prescaler value. Start restarts as above.
- DONE: CountValue holds 0 and Done deasserts after one cycle. Start restarts; all other inputs are ignored.
- IDLE: all outputs hold their reset values until Start.
- Tick and Done are 0 in every cycle not described above.
- Speed change while running takes effect at the next prescaler reload only.
- Decrement never wraps: CountValue=0 never decrements.
- Throughput: with Speed=0, one decrement per cycle. The first Tick comes divisor cycles after the Start edge.

Decomposition:
- Package timer_pkg holds:
  - state_t enum {IDLE, RUN, PAUSED, DONE};
  - speed code localparams SPD_FAST=0, SPD_1X=1, SPD_2X=2, SPD_4X=3;
  - the function divisor(Speed, BASE_DIV).
- Sub-module tick_gen holds the prescaler.
  - Inputs: Clock, Reset, load, hold, div_minus1.
  - Output: expire, meaning prescaler=0 and not hold.
  - The FSM and count register live in countdown_timer.

Test Plan:
- Reset, then BASE_DIV=4, Speed=0, LoadValue=3, Start pulse at edge k -> CountValue 3,2,1,0 after edges k..k+3; Tick=1 after k+1..k+3; Done=1 only after k+3; Running=0 from k+3.
- Speed=1, LoadValue=2, Start at k -> Tick and decrement after edges k+4 and k+8; Done with the second; no Tick in other cycles.
- Speed=1, LoadValue=5, Pause=1 for 10 cycles mid-run -> CountValue and prescaler frozen, no Tick, Running=0; after Pause=0, remaining interval completes (total Tick spacing = 4 + pause length).
- LoadValue=0 with Start -> next state DONE, Done=1 one cycle, no Tick, CountValue=0.
- Restart in RUN with LoadValue=7, plus Start and Pause together -> Start wins: CountValue=7, state RUN, prescaler reloaded.
- Reset asserted at count 2 in RUN -> next cycle all outputs 0, state IDLE, no Done; Speed changed mid-interval -> old interval finishes, new divisor from the next reload.
